// File: rtl/reg_file_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_file_scoreboard
//
// Register file for the 16-bit datapath, fed by the write-back data select.
// It provides two combinational read ports with same-cycle write-to-read
// bypass. It also keeps a per-register busy scoreboard that blocks issue on
// RAW and WAW hazards until the producing write-back arrives.
//
// Ports:
//   clk        system clock, rising-edge state updates
//   rst_n      asynchronous active-low reset (clears data, busy, count)
//   ReadReg1/2 source register indices
//   ReadData1/2 combinational, bypassed read data (index 0 reads 0)
//   SrcUse1/2  issuing instruction really consumes the matching source
//   RegWrite   write-back valid; WriteReg / WriteData give target and value
//   IssueValid instruction attempting issue; IssueDest its destination (0 = none)
//   Stall      combinational hazard stall
//   BusyCount  registered popcount of the busy vector
// ---------------------------------------------------------------------------
module reg_file_scoreboard #(
   parameter int DATA_WIDTH     = 16,
   parameter int REG_ADDR_WIDTH = 3,
   parameter int CNT_WIDTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] ReadReg1,
   input  logic [REG_ADDR_WIDTH-1:0] ReadReg2,
   output logic [DATA_WIDTH-1:0]     ReadData1,
   output logic [DATA_WIDTH-1:0]     ReadData2,
   input  logic                      SrcUse1,
   input  logic                      SrcUse2,
   input  logic                      RegWrite,
   input  logic [REG_ADDR_WIDTH-1:0] WriteReg,
   input  logic [DATA_WIDTH-1:0]     WriteData,
   input  logic                      IssueValid,
   input  logic [REG_ADDR_WIDTH-1:0] IssueDest,
   output logic                      Stall,
   output logic [CNT_WIDTH-1:0]      BusyCount
);

   localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_reg;
   logic [NUM_REGS-1:0]   busy_next;
   logic [CNT_WIDTH-1:0]  busy_count_reg;
   logic [CNT_WIDTH-1:0]  busy_count_next;

   logic wb_valid;
   logic wb_hit1;
   logic wb_hit2;
   logic wb_hitw;
   logic hz1;
   logic hz2;
   logic hzw;
   logic issue_accept;

   // A write-back to index 0 is discarded everywhere (data, bypass, busy clear).
   assign wb_valid = RegWrite && (WriteReg != '0);

   assign wb_hit1 = wb_valid && (WriteReg == ReadReg1);
   assign wb_hit2 = wb_valid && (WriteReg == ReadReg2);
   assign wb_hitw = wb_valid && (WriteReg == IssueDest);

   // Index 0 reads zero, and its storage is never written, so no bypass is
   // needed for it.
   assign ReadData1 = (ReadReg1 == '0) ? '0 : (wb_hit1 ? WriteData : regs_reg[ReadReg1]);
   assign ReadData2 = (ReadReg2 == '0) ? '0 : (wb_hit2 ? WriteData : regs_reg[ReadReg2]);

   // A write-back landing this cycle resolves the hazard on its register.
   // busy_reg[0] is constant 0, so index 0 never creates a hazard.
   assign hz1 = SrcUse1 && busy_reg[ReadReg1] && !wb_hit1;
   assign hz2 = SrcUse2 && busy_reg[ReadReg2] && !wb_hit2;
   assign hzw = (IssueDest != '0) && busy_reg[IssueDest] && !wb_hitw;

   assign Stall        = IssueValid && (hz1 || hz2 || hzw);
   assign issue_accept = IssueValid && !Stall && (IssueDest != '0);
   assign BusyCount    = busy_count_reg;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            // Register 0 is hardwired: constant storage, never busy.
            assign regs_reg[gi]  = '0;
            assign busy_next[gi] = 1'b0;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  busy_reg[gi] <= 1'b0;
               end else begin
                  busy_reg[gi] <= 1'b0;
               end
            end
         end else begin : g_live
            logic wr_sel;
            logic set_sel;

            assign wr_sel  = wb_valid && (WriteReg == REG_ADDR_WIDTH'(gi));
            assign set_sel = issue_accept && (IssueDest == REG_ADDR_WIDTH'(gi));

            // When a new producer issues in the same cycle as the old one
            // writes back, the new producer owns the register: set wins.
            assign busy_next[gi] = set_sel ? 1'b1 : (wr_sel ? 1'b0 : busy_reg[gi]);

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  regs_reg[gi] <= '0;
                  busy_reg[gi] <= 1'b0;
               end else begin
                  if (wr_sel) begin
                     regs_reg[gi] <= WriteData;
                  end
                  busy_reg[gi] <= busy_next[gi];
               end
            end
         end
      end
   endgenerate

   always_comb begin
      busy_count_next = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_count_next = busy_count_next + CNT_WIDTH'(busy_next[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_count_reg <= '0;
      end else begin
         busy_count_reg <= busy_count_next;
      end
   end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_file_scoreboard
//
// Drives directed and random register-file / scoreboard traffic. Expected
// read data, Stall and BusyCount come from an array-based reference model.
// They are pushed into a queue, and a separate monitor process compares
// them against the DUT outputs when a sample is signalled.
// ---------------------------------------------------------------------------
module tb_reg_file_scoreboard;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int CW = 4;
   localparam int NR = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] ReadReg1 = '0;
   logic [AW-1:0] ReadReg2 = '0;
   logic [DW-1:0] ReadData1;
   logic [DW-1:0] ReadData2;
   logic          SrcUse1 = 1'b0;
   logic          SrcUse2 = 1'b0;
   logic          RegWrite = 1'b0;
   logic [AW-1:0] WriteReg = '0;
   logic [DW-1:0] WriteData = '0;
   logic          IssueValid = 1'b0;
   logic [AW-1:0] IssueDest = '0;
   logic          Stall;
   logic [CW-1:0] BusyCount;

   always #5 clk = ~clk;

   reg_file_scoreboard #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .SrcUse1(SrcUse1), .SrcUse2(SrcUse2),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .IssueValid(IssueValid), .IssueDest(IssueDest),
      .Stall(Stall), .BusyCount(BusyCount)
   );

   typedef struct {
      int            txn;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic          stall;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   checks = 0;
   int   errors = 0;
   int   txn_id = 0;

   // Reference model state
   logic [DW-1:0] m_regs [NR];
   bit            m_busy [NR];

   function automatic bit wb_to(logic [AW-1:0] idx);
      return RegWrite && (WriteReg == idx) && (idx != '0);
   endfunction

   function automatic logic [DW-1:0] model_read(logic [AW-1:0] idx);
      if (idx == '0) return '0;
      if (wb_to(idx)) return WriteData;
      return m_regs[idx];
   endfunction

   function automatic logic model_stall();
      bit h1, h2, hw;
      h1 = SrcUse1 && m_busy[ReadReg1] && !wb_to(ReadReg1);
      h2 = SrcUse2 && m_busy[ReadReg2] && !wb_to(ReadReg2);
      hw = (IssueDest != '0) && m_busy[IssueDest] && !wb_to(IssueDest);
      return IssueValid && (h1 || h2 || hw);
   endfunction

   function automatic logic [CW-1:0] model_count();
      int n = 0;
      for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
      return CW'(n);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Clear from write-back first, then set from issue, so set wins.
   task automatic model_edge(input logic stall);
      if (RegWrite && WriteReg != '0) begin
         m_regs[WriteReg] = WriteData;
         m_busy[WriteReg] = 1'b0;
      end
      if (IssueValid && !stall && IssueDest != '0) m_busy[IssueDest] = 1'b1;
   endtask

   task automatic push_expected(output logic stall);
      exp_t e;
      e.txn   = txn_id;
      e.rd1   = model_read(ReadReg1);
      e.rd2   = model_read(ReadReg2);
      e.stall = model_stall();
      e.cnt   = model_count();
      stall   = e.stall;
      exp_q.push_back(e);
      txn_id++;
   endtask

   // Called just after a rising edge: drive, predict, sample at the falling
   // edge, then advance the model across the next rising edge.
   task automatic cycle(input logic rw, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic s1, input logic s2,
                        input logic iv, input logic [AW-1:0] id);
      logic st;
      RegWrite = rw; WriteReg = wr; WriteData = wd;
      ReadReg1 = r1; ReadReg2 = r2; SrcUse1 = s1; SrcUse2 = s2;
      IssueValid = iv; IssueDest = id;
      push_expected(st);
      @(negedge clk);
      -> sample_ev;
      @(posedge clk);
      model_edge(st);
      #1;
   endtask

   // Sample without involving the clock (used while reset is held).
   task automatic check_now();
      logic st;
      push_expected(st);
      #1;
      -> sample_ev;
      #1;
   endtask

   // Monitor: pops one expectation per sample and compares all outputs.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sample_without_expectation: actual sample, required none");
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (ReadData1 !== e.rd1) begin
               errors++;
               $display("FAIL txn%0d rd1: actual %h required %h", e.txn, ReadData1, e.rd1);
            end
            checks++;
            if (ReadData2 !== e.rd2) begin
               errors++;
               $display("FAIL txn%0d rd2: actual %h required %h", e.txn, ReadData2, e.rd2);
            end
            checks++;
            if (Stall !== e.stall) begin
               errors++;
               $display("FAIL txn%0d stall: actual %b required %b", e.txn, Stall, e.stall);
            end
            checks++;
            if (BusyCount !== e.cnt) begin
               errors++;
               $display("FAIL txn%0d busycount: actual %0d required %0d", e.txn, BusyCount, e.cnt);
            end
            $display("txn %0d rst_n=%b r1=%0d r2=%0d wb=%b/%0d/%h iss=%b/%0d rd1=%h rd2=%h stall=%b cnt=%0d",
                     e.txn, rst_n, ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData,
                     IssueValid, IssueDest, ReadData1, ReadData2, Stall, BusyCount);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Post-reset reads of every index on both ports
      for (int i = 0; i < NR; i++) begin
         cycle(1'b0, '0, '0, AW'(i), AW'(NR - 1 - i), 1'b0, 1'b0, 1'b0, '0);
      end

      // Write with bypass, then storage read; write to r0 is discarded
      cycle(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b1, 3'd0, 16'h1234, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0, '0);

      // RAW stall on port 2, ignored when SrcUse2 is low
      cycle(1'b0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5);
      cycle(1'b0, '0, '0, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd0);
      cycle(1'b0, '0, '0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 3'd0);

      // Write-back resolves the hazard in the same cycle, with bypass
      cycle(1'b1, 3'd5, 16'h00A5, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd0);
      cycle(1'b0, '0, '0, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0, '0);

      // WAW stall, then set-wins when issue and write-back share index 2
      cycle(1'b0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2);
      cycle(1'b0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2);
      cycle(1'b1, 3'd2, 16'h5A5A, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2);
      cycle(1'b0, '0, '0, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0);
      cycle(1'b1, 3'd2, 16'h0F0F, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, '0);

      // Fill the scoreboard, then hold a stalled issue
      for (int d = 1; d < NR; d++) begin
         cycle(1'b0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, AW'(d));
      end
      cycle(1'b0, '0, '0, 3'd3, 3'd5, 1'b1, 1'b0, 1'b1, 3'd0);

      // Reset between edges: everything clears without a clock
      #2;
      rst_n = 1'b0;
      model_reset();
      check_now();
      for (int i = 1; i < NR; i++) begin
         ReadReg1 = AW'(i);
         ReadReg2 = AW'(i);
         check_now();
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // A late write-back to a non-busy register is an ordinary write
      cycle(1'b1, 3'd4, 16'hC0DE, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, '0, '0, 3'd4, 3'd4, 1'b0, 1'b0, 1'b1, 3'd0);

      // Random traffic
      for (int n = 0; n < 200; n++) begin
         cycle(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
               AW'($urandom), AW'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), AW'($urandom));
      end

      #2;
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL leftover_expectations: actual %0d pending, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Register file for the 16-bit datapath, sitting directly downstream of the write-back data select.
- Accepts the selected write-back value (ALU result, memory load data or JAL link address) together with its destination register, and stores it.
- Serves two combinational read ports to decode, with same-cycle write-to-read bypass.
- Holds a per-register busy scoreboard that stalls issue on read-after-write (RAW) and write-after-write (WAW) hazards until the producing write-back arrives.

Parameters:
- DATA_WIDTH, 16: register and data width in bits.
- REG_ADDR_WIDTH, 3: register index width; number of registers = 2**REG_ADDR_WIDTH (8).
- CNT_WIDTH, 4: width of BusyCount; must hold 0..2**REG_ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ReadReg1  input  REG_ADDR_WIDTH  source register index, port 1.
- ReadReg2  input  REG_ADDR_WIDTH  source register index, port 2.
- ReadData1  output  DATA_WIDTH  value of ReadReg1 (combinational, bypassed).
- ReadData2  output  DATA_WIDTH  value of ReadReg2 (combinational, bypassed).
- SrcUse1  input  1  issuing instruction actually consumes ReadReg1.
- SrcUse2  input  1  issuing instruction actually consumes ReadReg2.
- RegWrite  input  1  write-back valid this cycle.
- WriteReg  input  REG_ADDR_WIDTH  write-back destination index.
- WriteData  input  DATA_WIDTH  write-back value from the write-back mux.
- IssueValid  input  1  an instruction is attempting to issue this cycle.
- IssueDest  input  REG_ADDR_WIDTH  destination of issuing instruction; 0 means no destination.
- Stall  output  1  issue blocked by a hazard (combinational).
- BusyCount  output  CNT_WIDTH  number of registers currently marked busy (registered).

Behaviour:
- Reset (rst_n low, asynchronous, no clock required):
  - All registers cleared to 0.
  - All busy bits cleared to 0.
  - BusyCount = 0.
  - With the bypass inactive, ReadData1/ReadData2 return 0 and Stall = 0.
- Register 0 is hardwired to zero:
  - Reads of index 0 always return 0, including under bypass.
  - Writes to index 0 are discarded.
  - busy[0] is never set.
- Write: at the rising edge of clk, if RegWrite and WriteReg != 0, then reg[WriteReg] <= WriteData. Write latency is 1 cycle.
- Read: ReadDataN = reg[ReadRegN], with no clock latency.
- Bypass: if RegWrite and WriteReg == ReadRegN and ReadRegN != 0, then ReadDataN = WriteData in the same cycle.
- Hazard on source N: hzN = SrcUseN && busy[ReadRegN] && !(RegWrite && WriteReg == ReadRegN).
- WAW hazard: hzW = IssueDest != 0 && busy[IssueDest] && !(RegWrite && WriteReg == IssueDest).
- Stall = IssueValid && (hz1 || hz2 || hzW).
- Busy set: at the edge, if IssueValid && !Stall && IssueDest != 0, then busy[IssueDest] <= 1.
- Busy clear: at the edge, if RegWrite && WriteReg != 0, then busy[WriteReg] <= 0.
- Simultaneous set and clear of the same index in one cycle: set wins. The new producer owns the register; the data write still occurs.
- Write-back to a register that is not busy is legal. The data is written and the busy bit stays 0.
- BusyCount is updated at the same edge to the popcount of the next busy vector. It never exceeds 2**REG_ADDR_WIDTH - 1, because busy[0] is never set.
- Reset asserted mid-operation: all state is cleared immediately. Write-backs still pending from before reset are treated as ordinary non-busy writes when they arrive.
- No X propagation: unused inputs (SrcUseN low, IssueValid low) must not affect Stall.

Test Plan:
- Reset, then read all indices 0..7 -> ReadData1/ReadData2 = 0x0000, Stall = 0, BusyCount = 0.
- RegWrite=1, WriteReg=3, WriteData=0xBEEF, with ReadReg1=3 in the same cycle -> ReadData1 = 0xBEEF (bypass). Next cycle with RegWrite=0 -> ReadData1 = 0xBEEF from storage. Repeat with WriteReg=0, WriteData=0x1234 -> reg0 still reads 0x0000.
- Issue IssueDest=5 (not stalled) -> BusyCount = 1. Next cycle, IssueValid=1, ReadReg2=5, SrcUse2=1 -> Stall = 1. Repeat with SrcUse2=0 -> Stall = 0.
- busy[5] set; same cycle RegWrite=1, WriteReg=5, WriteData=0x00A5, and issuing instruction reads reg 5 -> Stall = 0 and ReadData2 = 0x00A5. After the edge, busy[5] = 0 and BusyCount = 0.
- busy[2] set; issue IssueDest=2 with no write-back -> Stall = 1 (WAW). Issue IssueDest=2 in the same cycle as write-back WriteReg=2 -> Stall = 0, busy[2] remains 1, BusyCount unchanged.
- Mark registers 1..7 busy -> BusyCount = 7. Assert rst_n=0 between clock edges -> BusyCount = 0, all registers read 0x0000, and Stall deasserts immediately.
